// File: rtl/fifo_rd_stream_if.sv
// Valid/ready output stream carrying framed FIFO words (data plus end-of-packet flag).
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a show-ahead FIFO into a valid/ready stream through a 2-entry skid buffer, 1-cycle pop-to-output.
// Downstream stalls only block pops once both entries are full; the pop strobe never depends on m_ready.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    fifo_rd_stream_if.master      m,
    output logic [CNT_WIDTH-1:0]  rd_count
);
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_t;

    occ_t                  occ;
    occ_t                  occ_nxt;
    logic [DATA_WIDTH-1:0] data0;
    logic [DATA_WIDTH-1:0] data1;
    logic                  last0;
    logic                  last1;
    logic [BW-1:0]         beat_cnt;
    logic                  push;
    logic                  pop;
    logic                  push_last;

    assign push_last = (beat_cnt == BW'(PKT_LEN - 1));

    always_comb begin
        push    = 1'b0;
        pop     = 1'b0;
        occ_nxt = occ;
        push    = ~rd_rst & enable & ~fifo_empty & (occ != FULL);
        pop     = (occ != EMPTY) & m.m_ready;
        case (occ)
            EMPTY:   if (push) occ_nxt = ONE;
            ONE:     if (push & ~pop) occ_nxt = FULL;
                     else if (pop & ~push) occ_nxt = EMPTY;
            FULL:    if (pop) occ_nxt = ONE;
            default: occ_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            occ <= EMPTY;
        end else begin
            occ <= occ_nxt;
        end
    end

    // Entry 0 is always the head; entry 1 only holds the second word while FULL.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            data0    <= '0;
            data1    <= '0;
            last0    <= 1'b0;
            last1    <= 1'b0;
            beat_cnt <= '0;
            rd_count <= '0;
        end else begin
            case (occ)
                EMPTY: begin
                    if (push) begin
                        data0 <= fifo_rd_data;
                        last0 <= push_last;
                    end
                end
                ONE: begin
                    if (push & pop) begin
                        data0 <= fifo_rd_data;
                        last0 <= push_last;
                    end else if (push) begin
                        data1 <= fifo_rd_data;
                        last1 <= push_last;
                    end
                end
                FULL: begin
                    if (pop) begin
                        data0 <= data1;
                        last0 <= last1;
                    end
                end
                default: ;
            endcase
            if (push) begin
                beat_cnt <= push_last ? '0 : beat_cnt + BW'(1);
            end
            if (pop) begin
                rd_count <= rd_count + CNT_WIDTH'(1);
            end
        end
    end

    assign fifo_rd_en = push;
    assign m.m_valid  = (occ != EMPTY);
    assign m.m_data   = data0;
    assign m.m_last   = last0;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench: a queue-based show-ahead FIFO feeds the DUT; popped words are queued with their expected framing.
module tb_fifo_rd_stream;
    localparam int DW = 8;
    localparam int PL = 4;
    localparam int CW = 4;

    logic          rd_clk = 1'b0;
    logic          rd_rst;
    logic          enable;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic [CW-1:0] rd_count;

    fifo_rd_stream_if #(.DATA_WIDTH(DW)) m_if ();

    fifo_rd_stream #(
        .DATA_WIDTH (DW),
        .PKT_LEN    (PL),
        .CNT_WIDTH  (CW)
    ) dut (
        .rd_clk       (rd_clk),
        .rd_rst       (rd_rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .m            (m_if),
        .rd_count     (rd_count)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] fq[$];
    int            beat_m;
    logic [CW-1:0] cnt_m;
    int            errors;
    int            checks;
    int            acc_total;
    int            pop_total;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic load(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(base + DW'(i));
        refresh();
    endtask

    // One clock: sample and score at the falling edge, then retire the FIFO pop after the rising edge.
    task automatic cycle();
        logic do_pop;
        logic do_acc;
        exp_t e;
        @(negedge rd_clk);
        do_pop = fifo_rd_en;
        do_acc = m_if.m_valid & m_if.m_ready;
        if (rd_rst) begin
            check_val("rd_en_in_reset", {31'd0, fifo_rd_en}, 32'd0);
        end else begin
            check_val("rd_en", {31'd0, fifo_rd_en},
                      {31'd0, enable & ~fifo_empty & (sb.size() != 2)});
            check_val("m_valid", {31'd0, m_if.m_valid}, {31'd0, sb.size() != 0});
            check_val("rd_count", {28'd0, rd_count}, {28'd0, cnt_m});
            if (sb.size() != 0) begin
                check_val("m_data", {24'd0, m_if.m_data}, {24'd0, sb[0].d});
                check_val("m_last", {31'd0, m_if.m_last}, {31'd0, sb[0].l});
            end
            if (do_acc && sb.size() != 0) begin
                void'(sb.pop_front());
                cnt_m++;
                acc_total++;
            end
            if (do_pop) begin
                e.d = fifo_rd_data;
                e.l = (beat_m == PL - 1);
                sb.push_back(e);
                beat_m = (beat_m == PL - 1) ? 0 : beat_m + 1;
                pop_total++;
            end
        end
        @(posedge rd_clk);
        #1;
        if (do_pop && fq.size() != 0) void'(fq.pop_front());
        if (rd_rst) begin
            sb.delete();
            beat_m = 0;
            cnt_m  = '0;
        end
        refresh();
    endtask

    task automatic drain(input string tag, input int n, input int budget);
        int a0;
        int pa;
        int gaps;
        bit started;
        a0   = acc_total;
        gaps = 0;
        for (int i = 0; i < budget && (acc_total - a0) < n; i++) begin
            started = (acc_total > a0);
            pa      = acc_total;
            cycle();
            if (started && acc_total == pa) gaps++;
        end
        check_val({tag, "_words"}, acc_total - a0, n);
        check_val({tag, "_gaps"}, gaps, 0);
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        cycle();
        rd_rst = 1'b0;
    endtask

    initial begin
        int p0;
        errors    = 0;
        checks    = 0;
        acc_total = 0;
        pop_total = 0;
        beat_m    = 0;
        cnt_m     = '0;
        rd_rst    = 1'b1;
        enable    = 1'b1;
        m_if.m_ready = 1'b1;
        load(8'h10, 8);

        // Reset held with a non-empty FIFO
        repeat (4) cycle();
        rd_rst = 1'b0;
        check_val("rst_m_valid", {31'd0, m_if.m_valid}, 32'd0);
        check_val("rst_m_data", {24'd0, m_if.m_data}, 32'd0);
        check_val("rst_m_last", {31'd0, m_if.m_last}, 32'd0);
        check_val("rst_rd_count", {28'd0, rd_count}, 32'd0);

        // Streaming 0x10..0x17
        p0 = pop_total;
        cycle();
        check_val("first_pop", pop_total - p0, 1);
        drain("stream", 8, 40);
        check_val("stream_count", {28'd0, rd_count}, 32'd8);
        check_val("stream_rd_en_off", {31'd0, fifo_rd_en}, 32'd0);

        // Backpressure
        m_if.m_ready = 1'b0;
        load(8'hA0, 6);
        p0 = pop_total;
        repeat (10) cycle();
        check_val("bp_pops", pop_total - p0, 2);
        check_val("bp_head", {24'd0, m_if.m_data}, 32'hA0);
        m_if.m_ready = 1'b1;
        drain("bp_release", 6, 40);

        // Enable gating mid-packet
        do_reset();
        load(8'h30, 8);
        for (int i = 0; i < 20 && beat_m != 2; i++) cycle();
        check_val("gate_beat", beat_m, 2);
        enable = 1'b0;
        p0 = pop_total;
        repeat (5) cycle();
        check_val("gate_pops", pop_total - p0, 0);
        check_val("gate_drained", {31'd0, m_if.m_valid}, 32'd0);
        enable = 1'b1;
        drain("gate_resume", 6, 40);

        // Counter wrap at 2^CW
        do_reset();
        load(8'h40, 17);
        drain("wrap", 17, 60);
        check_val("wrap_final", {28'd0, rd_count}, 32'd1);

        // Mid-packet reset with one word buffered
        do_reset();
        load(8'h50, 7);
        drain("mid_pre", 2, 20);
        check_val("mid_buffered", {31'd0, m_if.m_valid}, 32'd1);
        do_reset();
        check_val("mid_count", {28'd0, rd_count}, 32'd0);
        check_val("mid_valid", {31'd0, m_if.m_valid}, 32'd0);
        check_val("mid_next_word", {24'd0, fifo_rd_data}, 32'h53);
        drain("mid_post", 4, 20);
        check_val("mid_count_end", {28'd0, rd_count}, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the dual-clock FIFO. It lives entirely in the read clock domain, pops words through the FIFO's read port (`rd_en` / `rd_data` / `empty`) and presents them on a valid/ready output stream. A 2-entry skid buffer isolates downstream backpressure from the FIFO pop decision. Words are framed into fixed-length packets, and delivered words are counted.

## Interface

Parameters:
- `DATA_WIDTH`, default 8: word width; must match the FIFO's `DATA_WIDTH`.
- `PKT_LEN`, default 4: words per packet; range 1..2^16; `m_last` marks the final word.
- `CNT_WIDTH`, default 16: width of the delivered-word counter.

Ports:
- `rd_clk`: input, 1 bit. Single clock, the FIFO read clock.
- `rd_rst`: input, 1 bit. Reset, synchronous, active-high.
- `enable`: input, 1 bit. When high, FIFO pops are allowed. When low, no new pops occur, but buffered words still drain.
- `fifo_empty`: input, 1 bit. FIFO `empty` flag.
- `fifo_rd_data`: input, `DATA_WIDTH` bits. FIFO `rd_data`, a show-ahead word that is valid whenever `fifo_empty` is 0.
- `fifo_rd_en`: output, 1 bit. Pop strobe to the FIFO `rd_en`.
- `m_data`: output, `DATA_WIDTH` bits. Output word.
- `m_valid`: output, 1 bit. Output word is valid.
- `m_last`: output, 1 bit. Current word is the last word of a packet; qualified by `m_valid`.
- `m_ready`: input, 1 bit. Downstream accepts the word.
- `rd_count`: output, `CNT_WIDTH` bits. Number of words accepted downstream, modulo 2^`CNT_WIDTH`.

## Operation

Buffer:
- Two entries, each holding data plus a last bit.
- `occ` is the occupancy, with states EMPTY (0), ONE (1) and FULL (2).
- Head entry drives `m_data` and `m_last`. `m_valid = (occ != 0)`.

Pop and push:
- `fifo_rd_en = ~rd_rst & enable & ~fifo_empty & (occ != 2)`. It is combinational from registered `occ`; there is no path from `m_ready`.
- push = `fifo_rd_en`. `fifo_rd_data` is captured into the tail entry on the same `rd_clk` edge.
- pop = `m_valid & m_ready`.

Occupancy transitions:
- push & ~pop: `occ` + 1.
- pop & ~push: `occ` − 1. In FULL, the second entry shifts to the head.
- push & pop: `occ` unchanged. In ONE, the new word becomes the head. In FULL, this case cannot occur because push is blocked.

Packet framing:
- `beat_cnt` ranges 0..`PKT_LEN`−1 and advances on each push.
- The last bit stored with a pushed word is `(beat_cnt == PKT_LEN-1)`. On that push, `beat_cnt` wraps to 0.
- `PKT_LEN`=1 gives `m_last` high on every word.

Counting:
- `rd_count` increments on every pop and wraps at 2^`CNT_WIDTH` to 0.

Ordering and loss:
- Words are delivered in FIFO order.
- No word is ever dropped or duplicated.

`enable` deassertion:
- Takes effect in the same cycle.
- `beat_cnt` is held, so a resumed stream continues the current packet.

Reset:
- When `rd_rst` is 1 at a clock edge, all state clears.
- Reset values: `occ`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `rd_count`=0, `beat_cnt`=0.
- `fifo_rd_en`=0 throughout any cycle in which `rd_rst` is high.
- A mid-packet reset discards buffered words. The first word popped after reset is beat 0.

## Timing

- Pop-to-output latency: a FIFO word popped in cycle N appears as `m_valid`/`m_data` in cycle N+1.
- Throughput: with `m_ready` held high and the FIFO non-empty, one word per cycle in steady state (`occ` stays at ONE).
- Output stability: once `m_valid` is 1, `m_data` and `m_last` hold until the cycle in which `m_ready` is 1.
- Backpressure: with `m_ready` low from the start, at most 2 pops occur, then `fifo_rd_en` stays 0.
- Backpressure release: on the first cycle `m_ready` is 1, `occ` drops to ONE at the next edge. `fifo_rd_en` re-asserts in that next cycle.
- `fifo_empty` dependency: `fifo_empty` arrives through the FIFO's 2-stage pointer synchronizer, so a word written in the write domain becomes poppable 2–3 `rd_clk` cycles later. This block adds no further delay beyond the 1-cycle buffer stage.

## Test plan

- **Reset:** hold `rd_rst`=1 with `fifo_empty`=0 and `enable`=1.
  - Expect `fifo_rd_en`=0 every cycle.
  - After release: `m_valid`=0, `m_data`=0, `m_last`=0, `rd_count`=0.
  - First pop occurs in the first cycle after release.
- **Streaming:** `PKT_LEN`=4, FIFO preloaded with 0x10..0x17, `m_ready`=1.
  - Expect 8 consecutive `m_valid` cycles carrying 0x10..0x17.
  - `m_last`=1 only on 0x13 and 0x17.
  - `rd_count`=8 at the end; `fifo_rd_en` drops when `fifo_empty` rises.
- **Backpressure:** `m_ready`=0, FIFO holds 0xA0..0xA5.
  - Expect exactly 2 `fifo_rd_en` pulses, then 0.
  - `m_data`=0xA0 held stable.
  - Raise `m_ready`: 0xA0..0xA5 delivered in order with no gaps after the first accept cycle.
- **Gating:** toggle `enable` low after the 2nd word of a packet, hold low 5 cycles, then raise it.
  - Expect no pops while `enable` is low; buffered words still delivered.
  - After resume, `m_last` lands on the 4th word of the packet counting across the pause.
- **Wrap:** `CNT_WIDTH`=4, stream 17 words.
  - Expect `rd_count` reading 15 → 0 → 1, final value 1.
- **Mid-packet reset:** assert `rd_rst` for 1 cycle after 2 words of a packet are delivered and 1 word is buffered.
  - Expect the buffered word to be discarded.
  - `rd_count`=0 after reset.
  - Next 4 words form a full packet, with `m_last` on the 4th.
